issue_queue_mem_ordered: RTL and testbench

Parametrised, age-ordered, collapsing issue queue for memory micro-ops. It sits between dispatch and the memory execution lanes and accepts up to DISPATCH_WIDTH uops per cycle. It issues up to ISSUE_WIDTH uops per cycle to the memory pipes, with registered outputs. It enforces conservative memory ordering, supports back-pressure per execution lane, and supports a pipeline flush.

---
 rtl/issue_queue_mem_ordered.sv | 162 ++++++++++++++++
 tb/tb_issue_queue_mem_ordered.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_mem_ordered.sv
// Age-ordered collapsing issue queue for memory uops: slot 0 is oldest, issued slots are squeezed
// out each cycle, and stores/loads obey conservative in-order memory rules.
package issue_queue_mem_ordered_pkg;
    localparam int unsigned UOP_PRF_IDX_W = 6;

    typedef enum logic {
        MEM_LD = 1'b0,
        MEM_ST = 1'b1
    } mem_type_t;

    typedef enum logic [1:0] {
        RS_NONE    = 2'd0,
        RS_FROM_RF = 2'd1,
        RS_IMM     = 2'd2
    } rs_src_t;

    typedef struct packed {
        logic                     valid;
        mem_type_t                mem_type;
        rs_src_t                  rs1_src;
        logic [UOP_PRF_IDX_W-1:0] rs1_idx;
        rs_src_t                  rs2_src;
        logic [UOP_PRF_IDX_W-1:0] rs2_idx;
        logic [7:0]               tag;
    } micro_op_t;
endpackage

module issue_queue_mem_ordered
    import issue_queue_mem_ordered_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned DISPATCH_WIDTH = 4,
    parameter int unsigned ISSUE_WIDTH    = 2,
    parameter int unsigned PRF_IDX_W      = UOP_PRF_IDX_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  micro_op_t              uop_in    [DISPATCH_WIDTH],
    output logic                   in_ready,
    output logic [PRF_IDX_W-1:0]   rs1_index [DEPTH],
    output logic [PRF_IDX_W-1:0]   rs2_index [DEPTH],
    input  logic [DEPTH-1:0]       rs1_busy,
    input  logic [DEPTH-1:0]       rs2_busy,
    input  logic [ISSUE_WIDTH-1:0] ex_ready,
    output micro_op_t              uop_out   [ISSUE_WIDTH],
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int unsigned SEL_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = SEL_W + 1;

    micro_op_t        slots_q   [DEPTH];
    micro_op_t        slots_d   [DEPTH];
    micro_op_t        uop_out_q [ISSUE_WIDTH];
    micro_op_t        uop_out_d [ISSUE_WIDTH];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [DEPTH-1:0] eligible;
    logic [DEPTH-1:0] taken;
    logic             any_in_valid;

    // Only registered occupancy counts; same-cycle issues are not credited.
    assign in_ready  = (OCC_W'(DEPTH) - occ_q) >= OCC_W'(DISPATCH_WIDTH);
    assign occupancy = occ_q;
    assign uop_out   = uop_out_q;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            rs1_index[k] = (slots_q[k].valid && slots_q[k].rs1_src == RS_FROM_RF) ?
                           slots_q[k].rs1_idx : '0;
            rs2_index[k] = (slots_q[k].valid && slots_q[k].rs2_src == RS_FROM_RF) ?
                           slots_q[k].rs2_idx : '0;
        end
    end

    // Stores go only from the head; loads never pass an older store.
    always_comb begin
        logic any_ahead;
        logic store_ahead;
        logic rs1_ok;
        logic rs2_ok;
        any_ahead   = 1'b0;
        store_ahead = 1'b0;
        eligible    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rs1_ok = (slots_q[k].rs1_src != RS_FROM_RF) || !rs1_busy[k];
            rs2_ok = (slots_q[k].rs2_src != RS_FROM_RF) || !rs2_busy[k];
            eligible[k] = slots_q[k].valid && rs1_ok && rs2_ok &&
                          ((slots_q[k].mem_type == MEM_ST) ? !any_ahead : !store_ahead);
            if (slots_q[k].valid) begin
                any_ahead = 1'b1;
                if (slots_q[k].mem_type == MEM_ST) store_ahead = 1'b1;
            end
        end
    end

    always_comb begin
        logic found;
        logic store_taken;
        taken       = '0;
        store_taken = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            uop_out_d[i] = '0;
            found        = 1'b0;
            if (ex_ready[i]) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (!found && eligible[k] && !taken[k] &&
                        !(store_taken && slots_q[k].mem_type == MEM_ST)) begin
                        found        = 1'b1;
                        taken[k]     = 1'b1;
                        uop_out_d[i] = slots_q[k];
                        if (slots_q[k].mem_type == MEM_ST) store_taken = 1'b1;
                    end
                end
            end
        end
    end

    // Survivors collapse toward slot 0, then accepted lanes pack in behind them.
    always_comb begin
        logic [OCC_W-1:0] n;
        n       = '0;
        slots_d = '{default: '0};
        for (int k = 0; k < DEPTH; k++) begin
            if (slots_q[k].valid && !taken[k]) begin
                slots_d[n[SEL_W-1:0]] = slots_q[k];
                n = n + OCC_W'(1);
            end
        end
        if (in_ready) begin
            for (int l = 0; l < DISPATCH_WIDTH; l++) begin
                if (uop_in[l].valid && n < OCC_W'(DEPTH)) begin
                    slots_d[n[SEL_W-1:0]] = uop_in[l];
                    n = n + OCC_W'(1);
                end
            end
        end
        occ_d = n;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            occ_q <= '0;
            for (int k = 0; k < DEPTH; k++) slots_q[k] <= '0;
            for (int i = 0; i < ISSUE_WIDTH; i++) uop_out_q[i] <= '0;
        end else begin
            occ_q <= occ_d;
            for (int k = 0; k < DEPTH; k++) slots_q[k] <= slots_d[k];
            for (int i = 0; i < ISSUE_WIDTH; i++) uop_out_q[i] <= uop_out_d[i];
        end
    end

    always_comb begin
        any_in_valid = 1'b0;
        for (int l = 0; l < DISPATCH_WIDTH; l++) any_in_valid = any_in_valid | uop_in[l].valid;
    end

    // Dispatch must hold off entirely while in_ready is low.
    no_dispatch_when_full: assert property (@(posedge clock) disable iff (reset || flush)
        !(any_in_valid && !in_ready));

endmodule

// File: tb/tb_issue_queue_mem_ordered.sv
// Directed bench for issue_queue_mem_ordered: stimulus pushes expected (cycle, lane, tag) issues
// into a scoreboard that an independent monitor drains as uop_out presents them.
module tb_issue_queue_mem_ordered;
    import issue_queue_mem_ordered_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 4;
    localparam int unsigned IW    = 2;
    localparam int unsigned PW    = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    micro_op_t        uop_in    [DW];
    logic             in_ready;
    logic [PW-1:0]    rs1_index [DEPTH];
    logic [PW-1:0]    rs2_index [DEPTH];
    logic [DEPTH-1:0] rs1_busy;
    logic [DEPTH-1:0] rs2_busy;
    logic [IW-1:0]    ex_ready;
    micro_op_t        uop_out   [IW];
    logic [4:0]       occupancy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int cyc;
        int lane;
        int tag;
    } exp_t;

    exp_t sb[$];

    issue_queue_mem_ordered #(
        .DEPTH(DEPTH),
        .DISPATCH_WIDTH(DW),
        .ISSUE_WIDTH(IW),
        .PRF_IDX_W(PW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .uop_in(uop_in),
        .in_ready(in_ready),
        .rs1_index(rs1_index),
        .rs2_index(rs2_index),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy),
        .ex_ready(ex_ready),
        .uop_out(uop_out),
        .occupancy(occupancy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every valid output lane must match the next scoreboard entry exactly.
    always @(negedge clock) begin
        for (int i = 0; i < IW; i++) begin
            if (uop_out[i].valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue: got lane %0d tag %0d cycle %0d, required none",
                             i, uop_out[i].tag, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.lane != i || e.tag != int'(uop_out[i].tag)) begin
                        errors++;
                        $display("FAIL issue_match: got cycle %0d lane %0d tag %0d, required cycle %0d lane %0d tag %0d",
                                 cyc, i, uop_out[i].tag, e.cyc, e.lane, e.tag);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input int c, input int lane, input int tag);
        exp_t e;
        e.cyc  = c;
        e.lane = lane;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic clear_in();
        for (int l = 0; l < DW; l++) uop_in[l] = '0;
    endtask

    // rs1 index = tag, rs2 index = tag+1, both sourced from the register file.
    function automatic micro_op_t mk(input int tag, input logic st);
        micro_op_t u;
        u          = '0;
        u.valid    = 1'b1;
        u.mem_type = st ? MEM_ST : MEM_LD;
        u.rs1_src  = RS_FROM_RF;
        u.rs1_idx  = PW'(tag);
        u.rs2_src  = RS_FROM_RF;
        u.rs2_idx  = PW'(tag + 1);
        u.tag      = 8'(tag);
        return u;
    endfunction

    initial begin
        int c;
        reset    = 1'b1;
        flush    = 1'b0;
        rs1_busy = '0;
        rs2_busy = '0;
        ex_ready = 2'b11;
        clear_in();
        repeat (2) tick();
        reset = 1'b0;
        check("reset_occ", 32'(occupancy), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_out0_valid", 32'(uop_out[0].valid), 0);
        check("reset_out1_valid", 32'(uop_out[1].valid), 0);

        // Four ready loads, both lanes open: two issue per cycle in age order.
        c = cyc;
        for (int l = 0; l < DW; l++) uop_in[l] = mk(1 + l, 1'b0);
        push(c + 2, 0, 1);
        push(c + 2, 1, 2);
        push(c + 3, 0, 3);
        push(c + 3, 1, 4);
        tick();
        clear_in();
        check("s1_occ4", 32'(occupancy), 4);
        check("s1_slot3_rs1", 32'(rs1_index[3]), 4);
        tick();
        check("s1_occ2", 32'(occupancy), 2);
        check("s1_slot0_rs1", 32'(rs1_index[0]), 3);
        check("s1_slot1_rs2", 32'(rs2_index[1]), 5);
        tick();
        check("s1_occ0", 32'(occupancy), 0);
        check("s1_empty_rs1", 32'(rs1_index[0]), 0);

        // Store then load in sparse lanes 1 and 3: packed, store issues alone first.
        c = cyc;
        uop_in[1] = mk(5, 1'b1);
        uop_in[3] = mk(6, 1'b0);
        push(c + 2, 0, 5);
        push(c + 3, 0, 6);
        tick();
        clear_in();
        check("s2_occ2", 32'(occupancy), 2);
        check("s2_pack0", 32'(rs1_index[0]), 5);
        check("s2_pack1", 32'(rs1_index[1]), 6);
        tick();
        check("s2_occ1", 32'(occupancy), 1);
        check("s2_load_head", 32'(rs1_index[0]), 6);
        tick();
        check("s2_occ0", 32'(occupancy), 0);

        // Load A blocked on rs1 busy; younger load B overtakes it.
        c = cyc;
        uop_in[0] = mk(7, 1'b0);
        rs1_busy  = 16'h0001;
        push(c + 3, 0, 8);
        push(c + 4, 0, 7);
        tick();
        uop_in[0] = mk(8, 1'b0);
        check("s3_occ1", 32'(occupancy), 1);
        check("s3_a_slot0", 32'(rs1_index[0]), 7);
        tick();
        clear_in();
        check("s3_occ2", 32'(occupancy), 2);
        tick();
        check("s3_occ_after_b", 32'(occupancy), 1);
        check("s3_a_still_slot0", 32'(rs1_index[0]), 7);
        rs1_busy = '0;
        tick();
        check("s3_occ0", 32'(occupancy), 0);

        // Lane 0 stalled: lane 1 still takes the oldest eligible load.
        c = cyc;
        ex_ready  = 2'b10;
        uop_in[0] = mk(9, 1'b0);
        uop_in[1] = mk(10, 1'b0);
        push(c + 2, 1, 9);
        push(c + 3, 1, 10);
        tick();
        clear_in();
        check("s5_occ2", 32'(occupancy), 2);
        tick();
        check("s5_occ1", 32'(occupancy), 1);
        check("s5_lane0_idle", 32'(uop_out[0].valid), 0);
        tick();
        check("s5_occ0", 32'(occupancy), 0);

        // Fill to DEPTH with no issue, then drain two per cycle.
        ex_ready = 2'b00;
        for (int g = 0; g < 4; g++) begin
            if (g == 3) begin
                check("s4_occ12", 32'(occupancy), 12);
                check("s4_ready_at12", 32'(in_ready), 1);
            end
            for (int l = 0; l < DW; l++) uop_in[l] = mk(20 + 4 * g + l, 1'b0);
            tick();
        end
        clear_in();
        check("s4_occ16", 32'(occupancy), 16);
        check("s4_not_ready16", 32'(in_ready), 0);
        tick();
        check("s4_hold16", 32'(occupancy), 16);
        c = cyc;
        ex_ready = 2'b11;
        for (int j = 0; j < 8; j++) begin
            push(c + 1 + j, 0, 20 + 2 * j);
            push(c + 1 + j, 1, 21 + 2 * j);
        end
        tick();
        check("s4_occ14", 32'(occupancy), 14);
        check("s4_not_ready14", 32'(in_ready), 0);
        tick();
        check("s4_occ12_drain", 32'(occupancy), 12);
        check("s4_ready12", 32'(in_ready), 1);
        repeat (6) tick();
        check("s4_drained", 32'(occupancy), 0);

        // Flush with a dispatch and pending issues in the same cycle.
        ex_ready = 2'b00;
        for (int l = 0; l < DW; l++) uop_in[l] = mk(40 + l, 1'b0);
        tick();
        check("s6_occ4", 32'(occupancy), 4);
        ex_ready = 2'b11;
        flush    = 1'b1;
        for (int l = 0; l < DW; l++) uop_in[l] = mk(44 + l, 1'b0);
        tick();
        flush = 1'b0;
        clear_in();
        check("s6_flush_occ", 32'(occupancy), 0);
        check("s6_flush_ready", 32'(in_ready), 1);
        check("s6_flush_out0", 32'(uop_out[0].valid), 0);
        check("s6_flush_out1", 32'(uop_out[1].valid), 0);
        check("s6_flush_rs1", 32'(rs1_index[0]), 0);
        repeat (3) tick();
        check("s6_still_empty", 32'(occupancy), 0);

        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
